// File: rtl/imem_stream_loader.sv
// Boot loader: packs a byte stream into little-endian words and writes
// them to instruction memory from address 0, holding the core until done.
//
// Ports:
//   clock, reset         rising-edge clock, synchronous active-high reset
//   start, word_count    load request and its length in words (IDLE only)
//   in_valid, in_data    byte stream input
//   in_ready             byte accepted when in_valid & in_ready
//   imem_we/addr/wdata   instruction-memory write port
//   core_hold            1 keeps the datapath in reset/stall
//   busy, done, error    load in progress, completion pulse, rejected start
module imem_stream_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WRITE,
    DONE
  } state_t;

  localparam logic [ADDR_W:0]   MAXW  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_W = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);

  state_t          state;
  logic [1:0]      bidx;
  logic [23:0]     acc;
  logic [ADDR_W:0] wcnt;
  logic            last;
  logic            cnt_ok;
  logic            take;

  assign last   = ({1'b0, imem_addr} == (wcnt - ONE_W));
  assign cnt_ok = (word_count != '0) && (word_count <= MAXW);
  assign take   = in_valid && in_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      bidx       <= 2'd0;
      acc        <= '0;
      wcnt       <= '0;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_hold  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (cnt_ok) begin
              state     <= RECV;
              bidx      <= 2'd0;
              imem_addr <= '0;
              wcnt      <= word_count;
              error     <= 1'b0;
              core_hold <= 1'b1;
              busy      <= 1'b1;
              in_ready  <= 1'b1;
            end else begin
              error <= 1'b1;
            end
          end
        end
        RECV: begin
          if (take) begin
            if (bidx == 2'd3) begin
              state      <= WRITE;
              imem_we    <= 1'b1;
              imem_wdata <= {in_data, acc};
              in_ready   <= 1'b0;
              bidx       <= 2'd0;
            end else begin
              // shift right so byte 0 ends in the low lane
              acc  <= {in_data, acc[23:8]};
              bidx <= bidx + 2'd1;
            end
          end
        end
        WRITE: begin
          imem_we <= 1'b0;
          if (last) begin
            state     <= DONE;
            done      <= 1'b1;
            core_hold <= 1'b0;
            busy      <= 1'b0;
          end else begin
            imem_addr <= imem_addr + ONE_A;
            in_ready  <= 1'b1;
            state     <= RECV;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_stream_loader.sv
// Randomized bench for imem_stream_loader with a cycle-level
// reference model and literal spot checks.
module tb_imem_stream_loader;

  localparam int AW = 8;
  localparam int DP = 256;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   word_count = '0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_hold;
  logic          busy;
  logic          done;
  logic          error;

  imem_stream_loader #(.ADDR_W(AW), .DEPTH(DP)) dut (
    .clock(clk),
    .reset(reset),
    .start(start),
    .word_count(word_count),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .core_hold(core_hold),
    .busy(busy),
    .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endfunction

  // Reference model: expected outputs for the current cycle, advanced
  // from the rules each cycle using the inputs seen before the edge.
  // loading = a load is active; nb = bytes of current word taken;
  // wpend = a word was just completed and is being written now;
  // fin = the completion cycle.
  bit          e_ready = 0, e_we = 0, e_busy = 0;
  bit          e_done = 0, e_err = 0, e_hold = 1;
  int          e_addr = 0;
  logic [31:0] e_wdata = '0;
  bit          loading = 0, wpend = 0, fin = 0;
  int          nb = 0, tgt = 0;
  logic [31:0] word = '0;

  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready), 32'(e_ready));
    chk("imem_we", 32'(imem_we), 32'(e_we));
    chk("imem_addr", 32'(imem_addr), 32'(e_addr));
    chk("imem_wdata", imem_wdata, e_wdata);
    chk("core_hold", 32'(core_hold), 32'(e_hold));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
    chk("error", 32'(error), 32'(e_err));
    if (reset) begin
      e_ready = 0; e_we = 0; e_addr = 0; e_wdata = '0;
      e_busy = 0; e_done = 0; e_err = 0; e_hold = 1;
      loading = 0; wpend = 0; fin = 0; nb = 0;
    end else if (fin) begin
      fin = 0;
      e_done = 0;
    end else if (wpend) begin
      wpend = 0;
      e_we = 0;
      if (e_addr == tgt - 1) begin
        loading = 0; fin = 1;
        e_done = 1; e_hold = 0; e_busy = 0;
      end else begin
        e_addr++;
        e_ready = 1;
      end
    end else if (loading) begin
      if (in_valid) begin
        word[8*nb +: 8] = in_data;
        nb++;
        if (nb == 4) begin
          nb = 0; wpend = 1;
          e_we = 1; e_wdata = word; e_ready = 0;
        end
      end
    end else if (start) begin
      if (word_count >= 1 && word_count <= DP) begin
        loading = 1; tgt = int'(word_count); nb = 0;
        e_addr = 0; e_err = 0; e_hold = 1;
        e_busy = 1; e_ready = 1;
      end else begin
        e_err = 1;
      end
    end
  end

  logic [7:0] bq[$];

  task automatic fill(input int n);
    bq.delete();
    for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int wc, input bit v);
    step();
    start = 1'b1;
    word_count = (AW+1)'(wc);
    in_valid = v;
    in_data = 8'hEE;
    step();
    start = 1'b0;
    in_valid = 1'b0;
  endtask

  // mode 0: back-to-back, 1: toggling, 2: random valid
  task automatic send(input int lo, input int hi, input int mode);
    int idx;
    int guard;
    idx = lo;
    guard = 0;
    while (idx < hi && guard < 20000) begin
      case (mode)
        0: in_valid = 1'b1;
        1: in_valid = ((guard % 2) == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = bq[idx];
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      step();
      guard++;
    end
    in_valid = 1'b0;
    if (idx < hi) chk("send_timeout", 32'(idx), 32'(hi));
  endtask

  task automatic wait_done();
    int n;
    bit seen;
    seen = 0;
    for (n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("done_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    repeat (3) step();
    reset = 1'b0;
    step();

    bq.delete();
    bq.push_back(8'h13); bq.push_back(8'h05);
    bq.push_back(8'hA0); bq.push_back(8'h00);
    do_start(1, 1'b1);
    send(0, 4, 0);
    @(negedge clk);
    chk("t1_we", 32'(imem_we), 32'd1);
    chk("t1_word", imem_wdata, 32'h00A00513);
    chk("t1_addr", 32'(imem_addr), 32'd0);
    chk("t1_hold_pre", 32'(core_hold), 32'd1);
    @(negedge clk);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_hold", 32'(core_hold), 32'd0);
    step();

    fill(12);
    do_start(3, 1'b1);
    send(0, 12, 1);
    wait_done();
    step();

    do_start(0, 1'b0);
    @(negedge clk);
    chk("err_zero", 32'(error), 32'd1);
    do_start(DP + 1, 1'b0);
    @(negedge clk);
    chk("err_big", 32'(error), 32'd1);
    chk("err_hold", 32'(core_hold), 32'd0);
    fill(8);
    do_start(2, 1'b0);
    @(negedge clk);
    chk("err_clr", 32'(error), 32'd0);
    send(0, 8, 2);
    wait_done();
    step();

    fill(8);
    do_start(2, 1'b0);
    send(0, 6, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_hold", 32'(core_hold), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    fill(4);
    do_start(1, 1'b0);
    send(0, 4, 2);
    wait_done();
    step();

    fill(16);
    do_start(4, 1'b0);
    send(0, 5, 0);
    do_start(2, 1'b0);
    send(5, 16, 2);
    wait_done();
    step();

    fill(4 * DP);
    do_start(DP, 1'b0);
    send(0, 4 * DP, 0);
    wait_done();
    chk("full_last", 32'(imem_addr), 32'(DP - 1));
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_stream_loader.md
Name: imem_stream_loader

Overview:
- Boot-time writer for the pipelined RISC-V datapath's instruction memory.
- Accepts a byte stream over a valid/ready handshake and packs each group of 4 bytes into a little-endian 32-bit instruction word.
- Writes each word into consecutive instruction-memory word addresses starting at 0.
- Holds the core in reset until the requested number of words has been written, then releases it, so PC=0 fetch sees the loaded program.

Parameters:
- ADDR_W, 8, word-address width of the instruction memory.
- DEPTH, 256, number of 32-bit words in the instruction memory (DEPTH <= 2^ADDR_W).

Ports:
- clock  in  1  system clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a load; sampled only in IDLE.
- word_count  in  ADDR_W+1  number of words to load; sampled with start.
- in_valid  in  1  in_data holds a valid byte.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  ADDR_W  word address for the write.
- imem_wdata  out  32  instruction word for the write.
- core_hold  out  1  drives the datapath reset/stall; 1 = core held.
- busy  out  1  load in progress (RECV or WRITE).
- done  out  1  one-cycle pulse when a load completes.
- error  out  1  sticky flag for a rejected start.

Behaviour:
- All outputs are registered. Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, error=0, core_hold=1. State=IDLE, byte index=0, word counter=0.
- IDLE:
  - in_ready=0.
  - start with 1 <= word_count <= DEPTH: go to RECV, clear byte index and address, latch word_count, clear error, set core_hold=1.
  - start with word_count=0 or word_count>DEPTH: stay in IDLE, set error=1 (held until the next accepted start), leave core_hold unchanged.
- RECV:
  - in_ready=1.
  - A byte is consumed only when in_valid&in_ready. Byte k (k=0..3) lands in bits 8k+7:8k, so the first byte is the LSB.
  - When byte 3 is consumed, go to WRITE; in_ready drops to 0 in the next cycle.
  - in_valid low: state and data hold, and no timeout applies.
- WRITE (exactly one cycle):
  - imem_we=1, with imem_addr = current word address and imem_wdata = the assembled word. in_ready=0.
  - Next cycle, imem_we=0.
  - If this was word word_count-1, go to DONE. Otherwise increment the address and return to RECV with byte index 0.
- DONE (one cycle): done=1, core_hold=0, busy=0, then go to IDLE.
- Latency: last byte accepted in cycle N. imem_we is high in cycle N+1. done=1 and core_hold=0 in cycle N+2.
- Throughput: each word costs at least 5 cycles (4 accept + 1 write).
- core_hold stays 0 after a successful load until reset or the next accepted start.
- start while busy is ignored, and error is unchanged.
- The address never wraps. Writes stop at word_count-1, and word_count=DEPTH writes address DEPTH-1 last.
- reset mid-load returns everything to reset values on the next edge. A partially assembled word is discarded and never written. core_hold=1.
- start and in_valid asserted in the same IDLE cycle: the byte is not consumed (in_ready=0 in IDLE). The first byte can be consumed in the following cycle.

Test Plan:
- Reset, then start with word_count=1 and bytes 0x13,0x05,0xA0,0x00 sent back-to-back -> one imem_we pulse with addr=0 and wdata=0x00A00513. done pulses 2 cycles after the last byte. core_hold goes 1->0 in the same cycle as done.
- word_count=3 with 12 bytes and in_valid toggling 1/0 every cycle -> exactly 3 writes to addrs 0,1,2 with the correct little-endian words. No byte is consumed while in_valid=0.
- start with word_count=0, then with word_count=DEPTH+1 -> error=1, no imem_we, state stays IDLE. A following valid start clears error.
- word_count=2, assert reset after 6 bytes (one word written, 2 bytes pending) -> all outputs return to reset values and core_hold=1. The pending word is never written. A new load then writes from addr 0.
- A second start pulse mid-load (word_count=4, second start after 5 bytes) -> ignored. Exactly 4 writes occur and done pulses once.
- Full-depth load with word_count=DEPTH -> last write at addr DEPTH-1, no wrap, and a single done pulse.
